// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter with packet lock in front of the uart_wrap TX port
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int HOLDOFF      = 2,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int IDW          = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              txempty,
  output logic [7:0]        txdata,
  output logic              write,
  output logic [IDW-1:0]    owner,
  output logic              locked,
  output logic              timeout
);

  localparam int HCW = $clog2(HOLDOFF + 1);
  localparam int ICW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOCKED, WRITE, HOLD} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [HCW-1:0] hold_cnt;
  logic [ICW-1:0] idle_cnt;

  logic           grant_valid;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] scan_idx;
  logic [IDW-1:0] sel_idx;
  logic [7:0]     sel_data;
  logic           sel_last;
  logic           accept;
  logic [IDW-1:0] rr_next;

  // Scan from the farthest candidate back to rr_ptr so the nearest valid one wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ))
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      scan_idx = scan_sum[IDW-1:0];
      if (req_valid[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Ready is withheld during reset so no byte is taken that would never be written.
  always_comb begin
    req_ready = '0;
    if (!rst && txempty) begin
      if (state == IDLE && grant_valid)
        req_ready[grant_idx] = 1'b1;
      else if (state == LOCKED && req_valid[owner])
        req_ready[owner] = 1'b1;
    end
  end

  assign accept   = |req_ready;
  assign sel_idx  = (state == LOCKED) ? owner : grant_idx;
  assign sel_data = req_data[{sel_idx, 3'b000} +: 8];
  assign sel_last = req_last[sel_idx];
  assign rr_next  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      write    <= 1'b0;
      txdata   <= '0;
      owner    <= '0;
      locked   <= 1'b0;
      timeout  <= 1'b0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      write   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            txdata   <= sel_data;
            owner    <= grant_idx;
            rr_ptr   <= rr_next;
            locked   <= !sel_last;
            idle_cnt <= '0;
            write    <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          hold_cnt <= HCW'(HOLDOFF - 1);
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == '0)
            state <= locked ? LOCKED : IDLE;
          else
            hold_cnt <= hold_cnt - 1'b1;
        end
        LOCKED: begin
          if (accept) begin
            txdata   <= sel_data;
            locked   <= !sel_last;
            idle_cnt <= '0;
            write    <= 1'b1;
            state    <= WRITE;
          end else if (LOCK_TIMEOUT != 0 && idle_cnt == ICW'(LOCK_TIMEOUT - 1)) begin
            locked   <= 1'b0;
            timeout  <= 1'b1;
            idle_cnt <= '0;
            state    <= IDLE;
          end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench with a transaction-level reference model for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int HOLDOFF = 2;
  localparam int LT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ready;
  logic              txempty = 1'b1;
  logic [7:0]        txdata;
  logic              write;
  logic [1:0]        owner;
  logic              locked;
  logic              timeout;

  uart_tx_arbiter #(.NREQ(NREQ), .HOLDOFF(HOLDOFF), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .txempty(txempty),
    .txdata(txdata), .write(write), .owner(owner), .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // requester sources: per-requester byte FIFOs of {last, data}
  logic [8:0] mem [NREQ][8];
  int head [NREQ] = '{default: 0};
  int tail [NREQ] = '{default: 0};
  logic [NREQ-1:0] took = '0;

  task automatic push(input int r, input logic last, input logic [7:0] d);
    mem[r][tail[r]] = {last, d};
    tail[r]++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (took[i] && head[i] < tail[i]) head[i]++;
        if (head[i] < tail[i]) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = mem[i][head[i]][7:0];
          req_last[i] = mem[i][head[i]][8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  // event logs
  int acc_cyc[$], acc_req[$], wr_cyc[$], wr_dat[$], wr_own[$], wr_lck[$], to_cyc[$];

  // reference model: accept eligibility expressed as a cooldown after each accepted byte
  int m_wait = 0, m_idle = 0, m_rr = 0, m_owner = 0, mj = 0, mg = 0;
  bit m_locked = 0, m_write = 0, m_timeout = 0, m_was_locked = 0;
  logic [7:0] m_txdata = 8'h00;
  logic [NREQ-1:0] exp_ready;

  always @(negedge clk) begin
    took = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++)
      if (took[i]) begin acc_cyc.push_back(cyc); acc_req.push_back(i); end
    if (write === 1'b1) begin
      wr_cyc.push_back(cyc); wr_dat.push_back(int'(txdata));
      wr_own.push_back(int'(owner)); wr_lck.push_back(int'(locked));
    end
    if (timeout === 1'b1) to_cyc.push_back(cyc);

    exp_ready = '0;
    if (!rst && m_wait == 0 && txempty) begin
      if (m_locked) begin
        if (req_valid[m_owner]) exp_ready[m_owner] = 1'b1;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          mj = (m_rr + k) % NREQ;
          if (exp_ready == '0 && req_valid[mj]) exp_ready[mj] = 1'b1;
        end
      end
    end
    chk("req_ready", req_ready, exp_ready);
    chk("write", write, m_write);
    chk("txdata", txdata, m_txdata);
    chk("owner", owner, m_owner);
    chk("locked", locked, m_locked);
    chk("timeout", timeout, m_timeout);

    if (rst) begin
      m_wait = 0; m_idle = 0; m_rr = 0; m_owner = 0;
      m_locked = 0; m_write = 0; m_timeout = 0; m_txdata = 8'h00;
    end else begin
      m_write = 0;
      m_timeout = 0;
      if (exp_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (exp_ready[i]) mg = i;
        m_was_locked = m_locked;
        m_txdata = req_data[8*mg +: 8];
        m_owner = mg;
        m_locked = !req_last[mg];
        m_write = 1;
        m_wait = HOLDOFF + 1;
        m_idle = 0;
        if (!m_was_locked) m_rr = (mg + 1) % NREQ;
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (m_locked) begin
        m_idle++;
        if (m_idle == LT) begin
          m_timeout = 1; m_locked = 0; m_idle = 0;
        end
      end
    end
  end

  task automatic wait_acc(input int n);
    int t;
    t = 0;
    while (acc_cyc.size() < n && t < 300) begin @(negedge clk); #1; t++; end
    chk("wait_acc", acc_cyc.size() >= n, 1);
  endtask

  task automatic wait_wr(input int n);
    int t;
    t = 0;
    while (wr_cyc.size() < n && t < 300) begin @(negedge clk); #1; t++; end
    chk("wait_wr", wr_cyc.size() >= n, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin head[i] = 0; tail[i] = 0; end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    acc_cyc.delete(); acc_req.delete(); wr_cyc.delete(); wr_dat.delete();
    wr_own.delete(); wr_lck.delete(); to_cyc.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_write"}, write, 0);
    chk({tag, "_txdata"}, txdata, 0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int c;
  logic [7:0] exp_b2 [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
  int exp_o2 [5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_b3 [4] = '{8'ha0, 8'ha1, 8'ha2, 8'hb0};
  int exp_o3 [4] = '{2, 2, 2, 1};
  int exp_l3 [4] = '{1, 1, 0, 0};

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_reset_outputs("por");

    // single-byte packet from requester 0
    push(0, 1'b1, 8'h41);
    wait_wr(1);
    chk("t1_latency", wr_cyc[0] - acc_cyc[0], 1);
    chk("t1_req", acc_req[0], 0);
    chk("t1_data", wr_dat[0], 32'h41);
    chk("t1_lock", wr_lck[0], 0);

    // four requesters, round-robin from 0
    do_reset();
    push(0, 1'b1, 8'h10); push(1, 1'b1, 8'h11); push(2, 1'b1, 8'h12);
    push(3, 1'b1, 8'h13); push(0, 1'b1, 8'h14);
    wait_wr(5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_data", wr_dat[i], exp_b2[i]);
      chk("t2_owner", wr_own[i], exp_o2[i]);
      if (i > 0) chk("t2_spacing", wr_cyc[i] - wr_cyc[i-1], HOLDOFF + 2);
    end

    // locked 3-byte packet from requester 2 while requester 1 waits
    do_reset();
    push(2, 1'b0, 8'ha0); push(2, 1'b0, 8'ha1); push(2, 1'b1, 8'ha2);
    wait_acc(1);
    push(1, 1'b1, 8'hb0);
    wait_wr(4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_data", wr_dat[i], exp_b3[i]);
      chk("t3_owner", wr_own[i], exp_o3[i]);
      chk("t3_locked", wr_lck[i], exp_l3[i]);
      if (i > 0) chk("t3_spacing", wr_cyc[i] - wr_cyc[i-1], 4);
    end

    // transmitter busy for 50 cycles
    do_reset();
    txempty = 1'b0;
    push(0, 1'b1, 8'h55);
    repeat (50) @(posedge clk);
    #2;
    chk("t4_no_accept", acc_cyc.size(), 0);
    chk("t4_no_write", wr_cyc.size(), 0);
    txempty = 1'b1;
    c = cyc;
    wait_acc(1);
    chk("t4_accept_cycle", acc_cyc[0], c);
    wait_wr(1);
    chk("t4_data", wr_dat[0], 32'h55);

    // lock timeout after an unfinished packet from requester 3
    do_reset();
    push(3, 1'b0, 8'h77);
    wait_acc(1);
    push(0, 1'b1, 8'h88);
    wait_wr(2);
    chk("t5_timeouts", to_cyc.size(), 1);
    chk("t5_timeout_cycle", to_cyc[0] - acc_cyc[0], HOLDOFF + 2 + LT);
    chk("t5_next_req", acc_req[1], 0);
    chk("t5_next_cycle", acc_cyc[1], to_cyc[0]);
    chk("t5_next_data", wr_dat[1], 32'h88);
    chk("t5_next_lock", wr_lck[1], 0);

    // reset during WRITE
    do_reset();
    push(1, 1'b0, 8'h21); push(1, 1'b1, 8'h22); push(3, 1'b1, 8'h33);
    wait_acc(1);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #1;
    chk_reset_outputs("t6a");
    wait_wr(3);
    chk("t6a_first_write", wr_cyc[0] - acc_cyc[0], 1);
    chk("t6a_restart", acc_cyc[1] - acc_cyc[0], 2);
    chk("t6a_data1", wr_dat[1], 32'h22);
    chk("t6a_owner1", wr_own[1], 1);
    chk("t6a_data2", wr_dat[2], 32'h33);
    chk("t6a_owner2", wr_own[2], 3);

    // reset while LOCKED
    do_reset();
    push(2, 1'b0, 8'h61); push(2, 1'b1, 8'h62);
    wait_acc(1);
    push(3, 1'b1, 8'h3c);
    @(posedge clk); #2;
    txempty = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("t6b_locked_before", locked, 1);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    txempty = 1'b1;
    @(negedge clk); #1;
    chk_reset_outputs("t6b");
    wait_wr(3);
    chk("t6b_gap", wr_cyc[1] - acc_cyc[0], 7);
    chk("t6b_data1", wr_dat[1], 32'h62);
    chk("t6b_owner1", wr_own[1], 2);
    chk("t6b_lock1", wr_lck[1], 0);
    chk("t6b_data2", wr_dat[2], 32'h3c);
    chk("t6b_owner2", wr_own[2], 3);

    repeat (10) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
